// File: rtl/asrm_mem_bridge_pkg.sv
// asrm_mem_bridge_pkg
//  Shared definitions for the asrm memory bridge: FSM state encodings and
//  default parameter values.
package asrm_mem_bridge_pkg;

    // Bridge FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ASRM_BR_IDLE = 2'd0,
        ASRM_BR_REQ  = 2'd1,
        ASRM_BR_DONE = 2'd2
    } asrm_br_state_t;

    localparam int ASRM_BR_WORDSIZE = 16;
    localparam int ASRM_BR_TIMEOUT  = 15;

endpackage

// File: rtl/asrm_bridge_timer.sv
// asrm_bridge_timer
//  Counts cycles spent waiting for a bus acknowledge.
//  Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   clear    in   forces the count back to zero (wins over enable)
//   enable   in   increments the count by one this cycle
//   expired  out  high while the count equals timeout-1, i.e. during the
//                 last permitted wait cycle
module asrm_bridge_timer #(
    parameter int timeout = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // One extra count of headroom: the counter steps once more on the
    // abort edge before the following cycle clears it.
    localparam int CW = $clog2(timeout + 1);

    logic [CW-1:0] tcnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_reg <= '0;
        end else if (clear) begin
            tcnt_reg <= '0;
        end else if (enable) begin
            tcnt_reg <= tcnt_reg + 1'b1;
        end
    end

    assign expired = (tcnt_reg == CW'(timeout - 1));

endmodule

// File: rtl/asrm_mem_bridge.sv
// asrm_mem_bridge
//  Bridges asrm_addr's level-style RAM port onto a req/ack memory bus.
//  Each CPU write becomes exactly one bus write; reads go through a
//  single-entry line so repeated reads of one address cost no bus cycle.
//  Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   cpu_addr      in   address from asrm_addr
//   cpu_data_out  in   write data from asrm_addr
//   cpu_write_en  in   write request (level)
//   cpu_data_in   out  read data to asrm_addr (registered)
//   stall         out  CPU must hold all state while high
//   bus_err       out  sticky timeout flag
//   mem_addr      out  bus address (registered)
//   mem_wdata     out  bus write data (registered)
//   mem_we        out  bus write strobe, meaningful while mem_req=1
//   mem_req       out  bus request, held until ack or abort
//   mem_rdata     in   bus read data, sampled on mem_ack
//   mem_ack       in   one-cycle acknowledge
module asrm_mem_bridge
    import asrm_mem_bridge_pkg::*;
#(
    parameter int wordsize = ASRM_BR_WORDSIZE,
    parameter int timeout  = ASRM_BR_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_data_out,
    input  logic                cpu_write_en,
    output logic [wordsize-1:0] cpu_data_in,
    output logic                stall,
    output logic                bus_err,
    output logic [wordsize-1:0] mem_addr,
    output logic [wordsize-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_req,
    input  logic [wordsize-1:0] mem_rdata,
    input  logic                mem_ack
);

    asrm_br_state_t state_reg, state_next;

    logic [wordsize-1:0] mem_addr_reg;
    logic [wordsize-1:0] mem_wdata_reg;
    logic                mem_we_reg;
    logic [wordsize-1:0] line_addr_reg;
    logic                line_valid_reg;
    logic [wordsize-1:0] rdata_q_reg;
    logic                wr_done_reg;
    logic                bus_err_reg;

    logic stall_next;
    logic start_write;
    logic start_read;
    logic ack_fire;
    logic abort_fire;
    logic timer_expired;
    logic in_req;

    // Per-bit equality of the CPU port against the line tag and against the
    // last latched bus write, reduced below to full-width matches.
    logic [wordsize-1:0] line_eq_bits;
    logic [wordsize-1:0] waddr_eq_bits;
    logic [wordsize-1:0] wdata_eq_bits;
    logic                line_hit;
    logic                same_write;

    for (genvar gi = 0; gi < wordsize; gi++) begin : g_cmp
        assign line_eq_bits[gi]  = cpu_addr[gi]     ~^ line_addr_reg[gi];
        assign waddr_eq_bits[gi] = cpu_addr[gi]     ~^ mem_addr_reg[gi];
        assign wdata_eq_bits[gi] = cpu_data_out[gi] ~^ mem_wdata_reg[gi];
    end

    assign line_hit   = line_valid_reg & (&line_eq_bits);
    assign same_write = (&waddr_eq_bits) & (&wdata_eq_bits);

    assign in_req     = (state_reg == ASRM_BR_REQ);
    // Ack has priority over a simultaneous timeout.
    assign ack_fire   = in_req & mem_ack;
    assign abort_fire = in_req & ~mem_ack & timer_expired;

    asrm_bridge_timer #(
        .timeout (timeout)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_req),
        .enable  (in_req),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ASRM_BR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        stall_next  = 1'b0;
        start_write = 1'b0;
        start_read  = 1'b0;
        case (state_reg)
            ASRM_BR_IDLE: begin
                if (cpu_write_en) begin
                    // A write already performed for these exact inputs is
                    // not repeated while write_en stays high.
                    if (!wr_done_reg) begin
                        start_write = 1'b1;
                        stall_next  = 1'b1;
                        state_next  = ASRM_BR_REQ;
                    end
                end else if (!line_hit) begin
                    start_read = 1'b1;
                    stall_next = 1'b1;
                    state_next = ASRM_BR_REQ;
                end
            end
            ASRM_BR_REQ: begin
                stall_next = 1'b1;
                if (ack_fire || abort_fire) begin
                    state_next = ASRM_BR_DONE;
                end
            end
            ASRM_BR_DONE: begin
                state_next = ASRM_BR_IDLE;
            end
            default: begin
                state_next = ASRM_BR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            line_addr_reg  <= '0;
            line_valid_reg <= 1'b0;
            rdata_q_reg    <= '0;
            wr_done_reg    <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            if (start_write) begin
                mem_addr_reg  <= cpu_addr;
                mem_wdata_reg <= cpu_data_out;
                mem_we_reg    <= 1'b1;
            end else if (start_read) begin
                mem_addr_reg <= cpu_addr;
                mem_we_reg   <= 1'b0;
            end

            if (ack_fire) begin
                if (!mem_we_reg) begin
                    rdata_q_reg    <= mem_rdata;
                    line_addr_reg  <= mem_addr_reg;
                    line_valid_reg <= 1'b1;
                end else if (mem_addr_reg == line_addr_reg) begin
                    // Keep the line coherent with what was just written.
                    rdata_q_reg <= mem_wdata_reg;
                end
            end else if (abort_fire) begin
                bus_err_reg    <= 1'b1;
                line_valid_reg <= 1'b0;
                rdata_q_reg    <= '0;
            end

            // An aborted write still counts as done so a held write_en does
            // not retry forever against a dead bus.
            if ((ack_fire || abort_fire) && mem_we_reg) begin
                wr_done_reg <= 1'b1;
            end else if (!cpu_write_en || !same_write) begin
                wr_done_reg <= 1'b0;
            end
        end
    end

    // stall is combinational in IDLE; gate it so reset silences it at once.
    assign stall       = stall_next & reset;
    assign mem_req     = in_req;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_we      = mem_we_reg;
    assign cpu_data_in = rdata_q_reg;
    assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_asrm_mem_bridge.sv
module tb_asrm_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_data_out = '0;
    logic        cpu_write_en = 1'b0;
    logic [15:0] cpu_data_in;
    logic        stall;
    logic        bus_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    asrm_mem_bridge #(
        .wordsize (16),
        .timeout  (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_write_en (cpu_write_en),
        .cpu_data_in  (cpu_data_in),
        .stall        (stall),
        .bus_err      (bus_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_req      (mem_req),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } bus_t;

    typedef struct {
        string       name;
        logic [15:0] data;
        int          stalls;
        int          reqs;
        logic        err;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;
    bit pending = 1'b0;

    int          ack_delay = 0;
    logic [15:0] ack_data = '0;
    bit          stray = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Memory model: acks on the ack_delay-th REQ cycle (0 = never).
    int rq_cnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            rq_cnt++;
            mem_ack   = (ack_delay != 0) && (rq_cnt == ack_delay);
            mem_rdata = ack_data;
        end else begin
            rq_cnt  = 0;
            mem_ack = stray;
            if (stray) mem_rdata = 16'hDEAD;
        end
    end

    // Bus monitor: every new request must match the next expected one.
    logic prev_req = 1'b0;
    bus_t b;
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: actual request addr 0x%0h we %0b, required none", mem_addr, mem_we);
            end else begin
                b = exp_bus.pop_front();
                $display("bus request addr=0x%04h we=%0b wdata=0x%04h", mem_addr, mem_we, mem_wdata);
                check("bus_addr", 32'(mem_addr), 32'(b.addr));
                check("bus_we", 32'(mem_we), 32'(b.we));
                if (b.we) check("bus_wdata", 32'(mem_wdata), 32'(b.wdata));
            end
        end
        prev_req = mem_req;
    end

    // Response monitor: an access completes on the first cycle stall is low.
    int   stall_cnt = 0;
    int   req_cnt = 0;
    rsp_t r;
    always @(negedge clk) begin
        if (pending) begin
            if (stall) begin
                stall_cnt++;
                if (mem_req) req_cnt++;
            end else begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: actual completion, required none");
                end else begin
                    r = exp_rsp.pop_front();
                    $display("%s: data=0x%04h stalls=%0d reqs=%0d bus_err=%0b",
                             r.name, cpu_data_in, stall_cnt, req_cnt, bus_err);
                    check({r.name, "_data"}, 32'(cpu_data_in), 32'(r.data));
                    check({r.name, "_stalls"}, 32'(stall_cnt), 32'(r.stalls));
                    check({r.name, "_reqs"}, 32'(req_cnt), 32'(r.reqs));
                    check({r.name, "_bus_err"}, 32'(bus_err), 32'(r.err));
                end
                stall_cnt = 0;
                req_cnt   = 0;
                pending   = 1'b0;
            end
        end
    end

    task automatic access(input string name, input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata, input int ad, input logic [15:0] adata,
                          input bit bus_expected, input logic [15:0] e_data,
                          input int e_stalls, input int e_reqs, input logic e_err);
        bus_t eb;
        rsp_t er;
        @(posedge clk);
        #1;
        reset        = 1'b1;
        cpu_addr     = addr;
        cpu_write_en = we;
        cpu_data_out = wdata;
        ack_delay    = ad;
        ack_data     = adata;
        if (bus_expected) begin
            eb.addr = addr; eb.we = we; eb.wdata = wdata;
            exp_bus.push_back(eb);
        end
        er.name = name; er.data = e_data; er.stalls = e_stalls; er.reqs = e_reqs; er.err = e_err;
        exp_rsp.push_back(er);
        pending = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (!pending) break;
        end
        if (pending) begin
            checks++;
            errors++;
            $display("FAIL %s_complete: actual still stalled after 100 cycles, required completion", name);
            pending = 1'b0;
            if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
        end
    endtask

    initial begin
        bus_t eb;
        #200000;
        $display("FAIL watchdog: actual simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t eb;
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_bus_err", 32'(bus_err), 0);
        check("rst_cpu_data_in", 32'(cpu_data_in), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);

        // Leaving reset with addr 0 in read mode is an immediate miss.
        access("rd0_miss", 16'h0000, 1'b0, 16'h0000, 1, 16'h1111, 1'b1, 16'h1111, 2, 1, 1'b0);
        // Miss with ack in the third REQ cycle.
        access("rd40_miss", 16'h0040, 1'b0, 16'h0000, 3, 16'hBEEF, 1'b1, 16'hBEEF, 4, 3, 1'b0);
        access("rd40_hit", 16'h0040, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 16'hBEEF, 0, 0, 1'b0);

        // Stray ack in IDLE must change nothing.
        @(posedge clk); #1; stray = 1'b1;
        @(posedge clk); #1; stray = 1'b0;
        @(negedge clk); #1;
        check("stray_mem_req", 32'(mem_req), 0);
        check("stray_stall", 32'(stall), 0);
        check("stray_data", 32'(cpu_data_in), 32'h0000BEEF);
        access("rd40_hit_after_stray", 16'h0040, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 16'hBEEF, 0, 0, 1'b0);

        // Write-through with write_en held six cycles in total.
        access("wr40", 16'h0040, 1'b1, 16'h1234, 1, 16'h0000, 1'b1, 16'h1234, 2, 1, 1'b0);
        repeat (3) begin
            @(negedge clk); #1;
            check("wr_held_stall", 32'(stall), 0);
            check("wr_held_mem_req", 32'(mem_req), 0);
        end
        access("rd40_after_wr", 16'h0040, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 16'h1234, 0, 0, 1'b0);

        // Timeout, then a retry that succeeds.
        access("rd100_timeout", 16'h0100, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 16'h0000, 16, 15, 1'b1);
        access("rd100_retry", 16'h0100, 1'b0, 16'h0000, 2, 16'h5A5A, 1'b1, 16'h5A5A, 3, 2, 1'b1);

        // Reset in the middle of a REQ.
        @(posedge clk); #1;
        cpu_addr = 16'h0200; cpu_write_en = 1'b0; ack_delay = 0;
        eb.addr = 16'h0200; eb.we = 1'b0; eb.wdata = 16'h0000;
        exp_bus.push_back(eb);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_mem_req", 32'(mem_req), 1);
        reset = 1'b0;
        #1;
        $display("mid_req_reset: mem_req=%0b stall=%0b bus_err=%0b data=0x%04h", mem_req, stall, bus_err, cpu_data_in);
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_stall", 32'(stall), 0);
        check("midrst_bus_err", 32'(bus_err), 0);
        check("midrst_cpu_data_in", 32'(cpu_data_in), 0);
        repeat (2) @(negedge clk);
        check("bus_queue_empty", 32'(exp_bus.size()), 0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
